// File: rtl/alu_issue_ctrl_if.sv
// Bundle between the ALU issue stage, its command source, the ALU and
// the result consumer. slave is the issue stage's view, master the peer's.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [3:0]       cmd_select;
    logic             cmd_carry_in;
    logic             cmd_use_acc;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic             alu_mode;
    logic [3:0]       alu_select;
    logic             alu_carry_in;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry_out;
    logic             alu_compare;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_carry;
    logic             res_compare;

    logic [WIDTH-1:0] acc_value;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_select, cmd_carry_in,
        input  cmd_use_acc, cmd_a, cmd_b,
        input  alu_out, alu_carry_out, alu_compare,
        input  res_ready,
        output cmd_ready,
        output alu_mode, alu_select, alu_carry_in, alu_in_a, alu_in_b,
        output res_valid, res_data, res_carry, res_compare,
        output acc_value, busy
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_select, cmd_carry_in,
        output cmd_use_acc, cmd_a, cmd_b,
        output alu_out, alu_carry_out, alu_compare,
        output res_ready,
        input  cmd_ready,
        input  alu_mode, alu_select, alu_carry_in, alu_in_a, alu_in_b,
        input  res_valid, res_data, res_carry, res_compare,
        input  acc_value, busy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: command FIFO, registered ALU operands, result capture
// with accumulator, and a valid/ready result port.
module alu_issue_ctrl #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    alu_issue_ctrl_if.slave bus
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          PW1     = PW + 1;
    localparam logic [PW:0] DEPTH_L = PW1'(FIFO_DEPTH);

    typedef struct packed {
        logic             mode;
        logic [3:0]       select;
        logic             carry_in;
        logic             use_acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    cmd_t             mem [FIFO_DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [PW:0]      count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    cmd_t             head;
    cmd_t             cmd_in;

    state_t           state;
    logic             alu_mode_q;
    logic [3:0]       alu_select_q;
    logic             alu_carry_in_q;
    logic [WIDTH-1:0] alu_in_a_q;
    logic [WIDTH-1:0] alu_in_b_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_carry_q;
    logic             res_compare_q;
    logic [WIDTH-1:0] acc_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == DEPTH_L);

    // Push is gated by occupancy only, never by a same-cycle pop.
    assign push  = bus.cmd_valid && !full;
    assign head  = mem[rd_ptr[PW-1:0]];

    assign cmd_in.mode     = bus.cmd_mode;
    assign cmd_in.select   = bus.cmd_select;
    assign cmd_in.carry_in = bus.cmd_carry_in;
    assign cmd_in.use_acc  = bus.cmd_use_acc;
    assign cmd_in.a        = bus.cmd_a;
    assign cmd_in.b        = bus.cmd_b;

    // Head is popped from IDLE, or from HOLD when the result is taken.
    always_comb begin
        pop = 1'b0;
        unique case (state)
            IDLE:    pop = !empty;
            HOLD:    pop = bus.res_ready && !empty;
            default: pop = 1'b0;
        endcase
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= cmd_in;
        end
    end

    // FIFO pointers; reset flushes every queued command.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Issue FSM with registered ALU operands, result and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            alu_mode_q     <= 1'b0;
            alu_select_q   <= '0;
            alu_carry_in_q <= 1'b0;
            alu_in_a_q     <= '0;
            alu_in_b_q     <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_carry_q    <= 1'b0;
            res_compare_q  <= 1'b0;
            acc_q          <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q    <= bus.alu_out;
                    res_carry_q   <= bus.alu_carry_out;
                    res_compare_q <= bus.alu_compare;
                    acc_q         <= bus.alu_out;
                    res_valid_q   <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= empty ? IDLE : EXEC;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // acc here is always the last captured result: a pop never
            // happens before the previous operation has been captured.
            if (pop) begin
                alu_mode_q     <= head.mode;
                alu_select_q   <= head.select;
                alu_carry_in_q <= head.carry_in;
                alu_in_a_q     <= head.use_acc ? acc_q : head.a;
                alu_in_b_q     <= head.b;
            end
        end
    end

    assign bus.cmd_ready    = !full;
    assign bus.alu_mode     = alu_mode_q;
    assign bus.alu_select   = alu_select_q;
    assign bus.alu_carry_in = alu_carry_in_q;
    assign bus.alu_in_a     = alu_in_a_q;
    assign bus.alu_in_b     = alu_in_b_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_carry    = res_carry_q;
    assign bus.res_compare  = res_compare_q;
    assign bus.acc_value    = acc_q;
    assign bus.busy         = (state != IDLE) || !empty;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 16-bit ALU attached
// to its operand ports.
module tb_alu_issue_ctrl;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_issue_ctrl_if #(.WIDTH(16)) bus();

    alu_issue_ctrl #(
        .WIDTH(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {compare, carry_out, out}.
    function automatic logic [17:0] alu_f(input logic m, input logic [3:0] s,
                                          input logic ci, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [16:0] sum;
        logic [15:0] o;
        logic        co;
        sum = 17'd0;
        o   = 16'd0;
        co  = ci;
        if (m) begin
            case (s)
                4'd6:    o = a ^ b;
                4'd11:   o = a & b;
                4'd14:   o = a | b;
                default: o = ~a;
            endcase
        end else begin
            case (s)
                4'd9:    sum = {1'b0, a} + {1'b0, b} + 17'(ci);
                4'd12:   sum = {1'b0, a} + {1'b0, a} + 17'(ci);
                default: sum = {1'b0, a} + 17'(ci);
            endcase
            o  = sum[15:0];
            co = sum[16];
        end
        return {(a == b), co, o};
    endfunction

    // Combinational ALU model fed by the DUT's registered operands.
    always_comb begin
        logic [17:0] r;
        r = alu_f(bus.alu_mode, bus.alu_select, bus.alu_carry_in,
                  bus.alu_in_a, bus.alu_in_b);
        bus.alu_out       = r[15:0];
        bus.alu_carry_out = r[16];
        bus.alu_compare   = r[17];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic m, input logic [3:0] s, input logic ci,
                             input logic ua, input logic [15:0] a,
                             input logic [15:0] b);
        bus.cmd_valid    = 1'b1;
        bus.cmd_mode     = m;
        bus.cmd_select   = s;
        bus.cmd_carry_in = ci;
        bus.cmd_use_acc  = ua;
        bus.cmd_a        = a;
        bus.cmd_b        = b;
    endtask

    // Present a command at a falling edge and return just after the
    // rising edge that accepts it.
    task automatic push(input logic m, input logic [3:0] s, input logic ci,
                        input logic ua, input logic [15:0] a,
                        input logic [15:0] b);
        int n;
        n = 0;
        @(negedge clk);
        drive_cmd(m, s, ci, ua, a, b);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
    endtask

    logic [15:0] bp_exp [6] = '{16'h1000, 16'h1012, 16'h1024,
                                16'h1036, 16'h1048, 16'h105A};
    logic [3:0]  w_sel [10];
    logic        w_ua  [10];
    logic        w_ci  [10];
    logic [15:0] w_a   [10];
    logic [15:0] w_b   [10];
    logic [17:0] q [$];
    logic [17:0] r;
    logic [15:0] model_acc;
    logic [15:0] ea;
    logic [7:0]  lfsr;
    logic        rdy_prev;
    int          got;
    int          last;
    int          cyc;
    int          k;
    int          stale;

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_mode     = 1'b0;
        bus.cmd_select   = 4'd0;
        bus.cmd_carry_in = 1'b0;
        bus.cmd_use_acc  = 1'b0;
        bus.cmd_a        = 16'd0;
        bus.cmd_b        = 16'd0;
        bus.res_ready    = 1'b1;
        rst              = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_acc", 32'(bus.acc_value), 32'd0);
        check("rst_alu_in_a", 32'(bus.alu_in_a), 32'd0);
        check("rst_alu_sel", 32'(bus.alu_select), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b0;

        // Basic add: 3 + 5.
        push(1'b0, 4'd9, 1'b0, 1'b0, 16'h0003, 16'h0005);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("add_in_a", 32'(bus.alu_in_a), 32'h0003);
        check("add_in_b", 32'(bus.alu_in_b), 32'h0005);
        check("add_sel", 32'(bus.alu_select), 32'd9);
        check("add_valid_early", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("add_valid", 32'(bus.res_valid), 32'd1);
        check("add_data", 32'(bus.res_data), 32'h0008);
        check("add_cmp", 32'(bus.res_compare), 32'd0);
        check("add_carry", 32'(bus.res_carry), 32'd0);
        check("add_acc", 32'(bus.acc_value), 32'h0008);

        // Chained op: operand A from accumulator.
        push(1'b0, 4'd12, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("chain_in_a", 32'(bus.alu_in_a), 32'h0008);
        @(negedge clk);
        check("chain_data", 32'(bus.res_data), 32'h0010);
        check("chain_acc", 32'(bus.acc_value), 32'h0010);

        // Logic XOR of equal operands: compare and carry set.
        push(1'b1, 4'd6, 1'b1, 1'b0, 16'h1234, 16'h1234);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("xor_mode", 32'(bus.alu_mode), 32'd1);
        check("xor_cin", 32'(bus.alu_carry_in), 32'd1);
        @(negedge clk);
        check("xor_valid", 32'(bus.res_valid), 32'd1);
        check("xor_data", 32'(bus.res_data), 32'h0000);
        check("xor_cmp", 32'(bus.res_compare), 32'd1);
        check("xor_carry", 32'(bus.res_carry), 32'd1);
        @(negedge clk);
        check("xor_valid_pulse", 32'(bus.res_valid), 32'd0);

        // Backpressure: cmd0 held, cmds 1-4 fill the FIFO, cmd5 waits.
        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 4'd9, 1'b0, 1'b0, 16'h1000 + 16'(i), 16'h0011 * 16'(i));
        end
        @(negedge clk);
        drive_cmd(1'b0, 4'd9, 1'b0, 1'b0, 16'h1005, 16'h0055);
        check("bp_full", 32'(bus.cmd_ready), 32'd0);
        check("bp_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp_stall_valid", 32'(bus.res_valid), 32'd1);
            check("bp_stall_data", 32'(bus.res_data), 32'(bp_exp[0]));
            check("bp_stall_acc", 32'(bus.acc_value), 32'(bp_exp[0]));
        end
        bus.res_ready = 1'b1;
        rdy_prev = bus.cmd_ready;
        got  = 1;
        last = 0;
        cyc  = 0;
        while (got < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.cmd_valid && rdy_prev) bus.cmd_valid = 1'b0;
            if (cyc == 1) check("bp_blocked_when_full", 32'(bus.cmd_ready), 32'd1);
            rdy_prev = bus.cmd_ready;
            if (bus.res_valid) begin
                check("bp_order", 32'(bus.res_data), 32'(bp_exp[got]));
                if (got > 1) check("bp_rate", 32'(cyc - last), 32'd2);
                last = cyc;
                got++;
            end
        end
        check("bp_count", 32'(got), 32'd6);
        bus.cmd_valid = 1'b0;

        // Reset while holding a result with three commands queued.
        @(negedge clk);
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 4'd9, 1'b0, 1'b0, 16'h0100 + 16'(i), 16'h0001);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("mr_pre_valid", 32'(bus.res_valid), 32'd1);
        check("mr_pre_ready", 32'(bus.cmd_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_valid", 32'(bus.res_valid), 32'd0);
        check("mr_acc", 32'(bus.acc_value), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd0);
        check("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mr_alu_in_a", 32'(bus.alu_in_a), 32'd0);
        rst = 1'b0;
        bus.res_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.res_valid || bus.busy) stale++;
        end
        check("mr_no_stale", 32'(stale), 32'd0);

        // Ten commands through the FIFO with random result backpressure.
        for (int i = 0; i < 10; i++) begin
            w_sel[i] = (i % 3 == 0) ? 4'd12 : 4'd9;
            w_ua[i]  = (i % 3 == 2);
            w_ci[i]  = i[0];
            w_a[i]   = 16'hF000 + 16'h1111 * 16'(i);
            w_b[i]   = 16'h0F0F * 16'(i) + 16'h0003;
        end
        model_acc = 16'h0000;
        lfsr      = 8'hA5;
        k         = 0;
        got       = 0;
        @(negedge clk);
        drive_cmd(1'b0, w_sel[0], w_ci[0], w_ua[0], w_a[0], w_b[0]);
        rdy_prev = bus.cmd_ready;
        cyc = 0;
        while (got < 10 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.cmd_valid && rdy_prev) begin
                ea = w_ua[k] ? model_acc : w_a[k];
                r  = alu_f(1'b0, w_sel[k], w_ci[k], ea, w_b[k]);
                q.push_back(r);
                model_acc = r[15:0];
                k++;
                if (k < 10) drive_cmd(1'b0, w_sel[k], w_ci[k], w_ua[k], w_a[k], w_b[k]);
                else bus.cmd_valid = 1'b0;
            end
            rdy_prev = bus.cmd_ready;
            if (bus.res_valid) begin
                check("wrap_expected_pending", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0)
                    check("wrap_result", 32'({bus.res_compare, bus.res_carry, bus.res_data}),
                          32'(q[0]));
            end
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            bus.res_ready = lfsr[0];
            if (bus.res_valid && bus.res_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                got++;
            end
        end
        check("wrap_count", 32'(got), 32'd10);
        check("wrap_all_sent", 32'(k), 32'd10);
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("wrap_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 16-bit combinational ALU.
- Buffers operation commands in a small FIFO and drives the ALU operand/control ports from registers.
- Captures the ALU's combinational outputs one cycle later into a result register and an accumulator.
- Presents results downstream on a valid/ready handshake; an accumulator source option lets chained operations reuse the previous result as operand A.

Parameters:
WIDTH, 16, operand/result width (must match ALU)
FIFO_DEPTH, 4, command FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept command
cmd_mode  input  1  ALU mode (1 logic, 0 arithmetic)
cmd_select  input  4  ALU function select
cmd_carry_in  input  1  ALU carry in
cmd_use_acc  input  1  1: operand A taken from accumulator, cmd_a ignored
cmd_a  input  WIDTH  operand A
cmd_b  input  WIDTH  operand B
alu_mode  output  1  registered to ALU mode
alu_select  output  4  registered to ALU select
alu_carry_in  output  1  registered to ALU carry_in
alu_in_a  output  WIDTH  registered to ALU in_a
alu_in_b  output  WIDTH  registered to ALU in_b
alu_out  input  WIDTH  ALU result
alu_carry_out  input  1  ALU carry out
alu_compare  input  1  ALU equality flag
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  WIDTH  captured alu_out
res_carry  output  1  captured alu_carry_out
res_compare  output  1  captured alu_compare
acc_value  output  WIDTH  current accumulator
busy  output  1  state!=IDLE or FIFO non-empty

Behaviour:
- Reset (rst=1 at edge): FIFO flushed; state IDLE; every output register cleared to 0, including all alu_* outputs, res_valid, res_data, res_carry, res_compare and acc_value. This applies mid-operation: any in-flight or held result is discarded.
- cmd_ready = !fifo_full, purely from occupancy. A push is never accepted while full, even if a pop happens in the same cycle. A simultaneous push and pop when not full is legal; count is unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, load alu_* registers, go to EXEC; else stay. alu_* hold last values.
  - EXEC: alu_* stable for the whole cycle. At the edge, capture alu_out/alu_carry_out/alu_compare into res_*, set acc <= alu_out, set res_valid <= 1, go to HOLD.
  - HOLD: res_valid=1; res_* and acc stable.
    - If res_ready=0, stay.
    - If res_ready=1 and FIFO non-empty, pop and load alu_* at this edge, clear res_valid, go to EXEC.
    - If res_ready=1 and FIFO empty, clear res_valid, go to IDLE.
- Operand A on load: if cmd_use_acc, alu_in_a <= acc (value at that edge, i.e. the last captured result); else alu_in_a <= cmd_a. There is no hazard, because a pop never precedes capture of the prior op.
- Latency:
  - Handshake in cycle C.
  - alu_* carry the operation in cycle C+2 (empty FIFO, IDLE).
  - res_valid is high from cycle C+3.
- Throughput: one result per 2 cycles with res_ready held high.
- Ordering: results leave in strict command order; no command is dropped or duplicated.
- No arithmetic is done in this block; res_* are exact copies of ALU outputs. acc wraps naturally at WIDTH.

Test Plan:
- Reset, then push {mode=0, sel=9, a=0x0003, b=0x0005}, res_ready=1 -> alu_in_a=0x0003/alu_in_b=0x0005 in C+2; res_valid in C+3 with res_data=0x0008, res_compare=0; acc_value=0x0008.
- Chain: after the above, push {use_acc=1, mode=0, sel=12, a=0xFFFF} -> alu_in_a=0x0008 (cmd_a ignored); res_data=0x0010, acc=0x0010.
- Compare/carry: push {mode=1, sel=6, carry_in=1, a=b=0x1234} -> res_data=0x0000, res_compare=1, res_carry=1.
- Backpressure: hold res_ready=0 and push 6 commands back-to-back.
  - Expected: cmd0 is held in HOLD and cmds 1-4 fill the FIFO; cmd_ready drops; cmd5 is not accepted until the first release.
  - Then release res_ready=1: 5 results emerge in order, one every 2 cycles, with res_* stable while stalled.
- Reset mid-operation: assert rst for 1 cycle while in HOLD with 3 entries queued -> next cycle res_valid=0, acc_value=0, busy=0, cmd_ready=1; no stale result ever appears afterward.
- Wrap: push 10 commands through FIFO_DEPTH=4 with res_ready toggling pseudo-randomly -> all 10 results correct and in order (pointer wrap-around verified).
